// File: rtl/exe_muldiv_unit_if.sv
// Request/result bundle between the EXE stage and the iterative multiply/divide unit.
// Handshake: start is a request that is only honoured while busy=0 and done=0 (IDLE). A request
// is consumed on the edge at which it is sampled, and done pulses for one cycle when HI/LO are valid.
interface exe_muldiv_unit_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] Val1_in;
  logic [31:0] Val2_in;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] HI;
  logic [31:0] LO;
  logic        div_by_zero;

  modport master (
    output start, op, Val1_in, Val2_in, flush,
    input  busy, done, HI, LO, div_by_zero
  );

  modport slave (
    input  start, op, Val1_in, Val2_in, flush,
    output busy, done, HI, LO, div_by_zero
  );
endinterface

// File: rtl/exe_muldiv_unit.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU unit: 32 shift-add or restoring-divide steps on
// operand magnitudes, then a one-cycle sign fix-up, with a fixed 34-cycle start-to-done latency.
module exe_muldiv_unit (
  input  logic                     clk,
  input  logic                     rst,
  exe_muldiv_unit_if.slave         bus,
  output logic [1:0]               o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [4:0]  r_cnt;
  logic        r_is_div;
  logic        r_neg_a;
  logic        r_neg_b;
  logic        r_b_zero;
  logic [31:0] r_opnd;
  logic [63:0] r_acc;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        r_dz;

  logic        w_accept;
  logic        w_neg_a;
  logic        w_neg_b;
  logic [31:0] w_mag_a;
  logic [31:0] w_mag_b;
  logic [32:0] w_mul_sum;
  logic [63:0] w_mul_next;
  logic [32:0] w_shift;
  logic [33:0] w_diff;
  logic        w_qbit;
  logic [63:0] w_div_next;
  logic        w_sign_diff;
  logic [63:0] w_prod;
  logic [31:0] w_quo;
  logic [31:0] w_rem;

  assign w_accept = (r_state == S_IDLE) && bus.start && !bus.flush;

  // Signed ops work on magnitudes; the signs are remembered for the FIX cycle.
  assign w_neg_a = bus.op[0] & bus.Val1_in[31];
  assign w_neg_b = bus.op[0] & bus.Val2_in[31];
  assign w_mag_a = w_neg_a ? (32'd0 - bus.Val1_in) : bus.Val1_in;
  assign w_mag_b = w_neg_b ? (32'd0 - bus.Val2_in) : bus.Val2_in;

  // Multiply step: multiplier sits in the low half and shifts out as the product shifts in.
  assign w_mul_sum  = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_opnd} : 33'd0);
  assign w_mul_next = {w_mul_sum, r_acc[31:1]};

  // Restoring divide step: partial remainder in the high half, quotient builds in the low half.
  assign w_shift    = {r_acc[63:32], r_acc[31]};
  assign w_diff     = {1'b0, w_shift} - {2'b00, r_opnd};
  assign w_qbit     = ~w_diff[33];
  assign w_div_next = {(w_qbit ? w_diff[31:0] : w_shift[31:0]), r_acc[30:0], w_qbit};

  assign w_sign_diff = r_neg_a ^ r_neg_b;
  assign w_prod      = w_sign_diff ? (64'd0 - r_acc) : r_acc;
  assign w_quo       = r_b_zero ? 32'hFFFF_FFFF :
                       (w_sign_diff ? (32'd0 - r_acc[31:0]) : r_acc[31:0]);
  // With a zero divisor the remainder is the dividend magnitude, so this also restores Val1_in.
  assign w_rem       = r_neg_a ? (32'd0 - r_acc[63:32]) : r_acc[63:32];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    if (bus.flush) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (bus.start) w_next = S_RUN;
        S_RUN:  if (r_cnt == 5'd31) w_next = S_FIX;
        S_FIX:  w_next = S_DONE;
        S_DONE: w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt    <= 5'd0;
      r_is_div <= 1'b0;
      r_neg_a  <= 1'b0;
      r_neg_b  <= 1'b0;
      r_b_zero <= 1'b0;
      r_opnd   <= 32'd0;
      r_acc    <= 64'd0;
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
      r_dz     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_cnt    <= 5'd0;
        r_is_div <= bus.op[1];
        r_neg_a  <= w_neg_a;
        r_neg_b  <= w_neg_b;
        r_b_zero <= (bus.Val2_in == 32'd0);
        r_opnd   <= bus.op[1] ? w_mag_b : w_mag_a;
        r_acc    <= bus.op[1] ? {32'd0, w_mag_a} : {32'd0, w_mag_b};
      end else if (r_state == S_RUN) begin
        r_cnt <= r_cnt + 5'd1;
        r_acc <= r_is_div ? w_div_next : w_mul_next;
      end
      if ((r_state == S_FIX) && !bus.flush) begin
        if (r_is_div) begin
          r_hi <= w_rem;
          r_lo <= w_quo;
          r_dz <= r_b_zero;
        end else begin
          r_hi <= w_prod[63:32];
          r_lo <= w_prod[31:0];
          r_dz <= 1'b0;
        end
      end
    end
  end

  assign bus.busy        = (r_state == S_RUN) || (r_state == S_FIX);
  assign bus.done        = (r_state == S_DONE);
  assign bus.HI          = r_hi;
  assign bus.LO          = r_lo;
  assign bus.div_by_zero = r_dz;
  assign o_dbg_state     = r_state;

endmodule

// File: doc/exe_muldiv_unit.md
EXE_MULDIV_UNIT -- requirements
Module: exe_muldiv_unit

Interface
REQ-001 The block SHALL have no parameters; the data width is fixed at 32 bits.
REQ-002 clk  input  1  single clock; all state changes on posedge clk.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request from the EXE stage; sampled on posedge clk.
REQ-005 op  input  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-006 Val1_in  input  32  operand A (multiplicand or dividend), from the ID/EXE pipeline register.
REQ-007 Val2_in  input  32  operand B (multiplier or divisor), from the ID/EXE pipeline register.
REQ-008 flush  input  1  synchronous abort of any operation in progress.
REQ-009 busy  output  1  operation in progress; the EXE stage stalls the pipeline while high.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 HI  output  32  product[63:32] or remainder.
REQ-012 LO  output  32  product[31:0] or quotient.
REQ-013 div_by_zero  output  1  the last completed divide had divisor 0.

Function
REQ-014 The block SHALL have states IDLE, RUN, FIX and DONE.
REQ-015 Transition IDLE->RUN SHALL occur when start=1 and flush=0 at a clock edge. At that edge, op, |Val1_in| and |Val2_in| SHALL be latched; operands are taken as magnitudes only for signed ops.
REQ-016 RUN SHALL last exactly 32 cycles, driven by a 5-bit iteration counter.
  - Multiply: shift-add, one bit per cycle.
  - Divide: restoring, one quotient bit per cycle.
REQ-017 RUN->FIX SHALL occur after the 32nd iteration. FIX SHALL last one cycle and apply the sign correction:
  - MULT: negate the 64-bit product if the operand signs differ.
  - DIV: negate the quotient if the signs differ; the remainder SHALL take the dividend's sign.
REQ-018 FIX->DONE SHALL occur unconditionally. At that edge, HI, LO and div_by_zero SHALL be updated.
REQ-019 DONE SHALL last one cycle with done=1, then return to IDLE. Result: done is high in the 34th cycle after the start edge.
REQ-020 busy SHALL be 1 in RUN and FIX and 0 in IDLE and DONE.
REQ-021 start SHALL be accepted in IDLE only. start in RUN, FIX or DONE SHALL be ignored, with no queuing.
REQ-022 HI and LO SHALL hold their values except at the FIX->DONE edge.
REQ-023 Divide by zero: the block SHALL run the same 34-cycle latency with no early exit, then set div_by_zero=1, LO=32'hFFFFFFFF and HI=original Val1_in. Any completed multiply or nonzero divide SHALL clear div_by_zero.
REQ-024 DIV 0x80000000 / 0xFFFFFFFF SHALL yield LO=0x80000000, HI=0, with no trap.
REQ-025 flush=1 in any state SHALL force IDLE at the next edge.
  - busy and done SHALL be 0 next cycle.
  - HI, LO and div_by_zero SHALL be unchanged.
  - flush SHALL win over a simultaneous start.
REQ-026 Operand inputs SHALL be ignored except at the accepting edge; changes during RUN SHALL not affect the result.

Reset
REQ-027 rst=0 SHALL immediately, without a clock, force IDLE and clear busy, done, HI, LO, div_by_zero and the internal datapath registers to 0.
REQ-028 After rst deasserts, the first start SHALL be accepted at the first clock edge at which it is sampled high.
REQ-029 rst asserted mid-operation SHALL abandon the operation with no done pulse.

Verification
REQ-030 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001, done exactly 34 cycles after start, busy high for 33 cycles.
REQ-031 MULT -3 x 7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; MULT 0x80000000 x 0x80000000 -> HI=0x40000000, LO=0.
REQ-032 DIV -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7 / 2 -> LO=3, HI=1.
REQ-033 DIVU 100 / 0 -> div_by_zero=1, LO=0xFFFFFFFF, HI=0x00000064. A following MULTU 2 x 3 -> div_by_zero=0, LO=6.
REQ-034 Start MULTU 5 x 5 with prior HI/LO=1/2; pulse start at cycle 5 and flush at cycle 10 -> no done, busy=0 at cycle 11, HI/LO still 1/2. The next start then completes normally.
REQ-035 Drive rst=0 between edges at cycle 20 of a DIV -> all outputs 0 before the next edge, and no done follows after rst releases.
